// File: rtl/mode_counter.sv
// Parametrised up/down counter with a power-of-two prescaler, programmable wrap
// limit, optional saturation at the boundaries and a registered terminal-count pulse.
module mode_counter #(
  parameter int SIZE     = 8,
  parameter int DIV      = 0,
  parameter int TOP      = 0,
  parameter int SATURATE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            up,
  input  logic            load,
  input  logic [SIZE-1:0] load_value,
  output logic [SIZE-1:0] value,
  output logic            tc
);

  // With DIV=0 a 1-bit prescaler pinned at zero makes every enabled cycle a step.
  localparam int              PW      = (DIV > 0) ? DIV : 1;
  localparam logic [PW-1:0]   PRE_MAX = (DIV > 0) ? {PW{1'b1}} : PW'(0);
  localparam logic [PW-1:0]   PRE_ONE = PW'(1);
  localparam logic [SIZE-1:0] LIMIT   = (TOP != 0) ? SIZE'(TOP) : {SIZE{1'b1}};
  localparam logic [SIZE-1:0] ZERO    = SIZE'(0);
  localparam logic [SIZE-1:0] ONE     = SIZE'(1);
  localparam logic            SAT     = (SATURATE != 0) ? 1'b1 : 1'b0;

  logic [PW-1:0]   r_pre;
  logic [SIZE-1:0] r_value;
  logic            r_tc;

  logic [PW-1:0]   w_pre_nxt;
  logic [SIZE-1:0] w_value_nxt;
  logic            w_tc_nxt;
  logic            w_step;
  logic [SIZE:0]   w_up_res;
  logic [SIZE:0]   w_dn_res;

  // Returns {tc, next value} for an upward step.
  function automatic logic [SIZE:0] step_up(input logic [SIZE-1:0] v);
    logic [SIZE:0] res;
    if (v >= LIMIT) begin
      res = {1'b1, (SAT ? LIMIT : ZERO)};
    end else begin
      res = {1'b0, v + ONE};
    end
    return res;
  endfunction

  // Returns {tc, next value} for a downward step; values above LIMIT walk down normally.
  function automatic logic [SIZE:0] step_down(input logic [SIZE-1:0] v);
    logic [SIZE:0] res;
    if (v == ZERO) begin
      res = {1'b1, (SAT ? ZERO : LIMIT)};
    end else begin
      res = {1'b0, v - ONE};
    end
    return res;
  endfunction

  assign w_step   = en && (r_pre == PRE_MAX);
  assign w_up_res = step_up(r_value);
  assign w_dn_res = step_down(r_value);

  // Next-state selection: load beats step beats hold.
  always_comb begin
    w_pre_nxt   = r_pre;
    w_value_nxt = r_value;
    w_tc_nxt    = 1'b0;
    if (load) begin
      w_pre_nxt   = PW'(0);
      w_value_nxt = load_value;
    end else if (en) begin
      w_pre_nxt = (r_pre == PRE_MAX) ? PW'(0) : (r_pre + PRE_ONE);
      if (w_step) begin
        if (up) begin
          w_value_nxt = w_up_res[SIZE-1:0];
          w_tc_nxt    = w_up_res[SIZE];
        end else begin
          w_value_nxt = w_dn_res[SIZE-1:0];
          w_tc_nxt    = w_dn_res[SIZE];
        end
      end else begin
        w_value_nxt = r_value;
      end
    end else begin
      w_pre_nxt = r_pre;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre   <= PW'(0);
      r_value <= ZERO;
      r_tc    <= 1'b0;
    end else begin
      r_pre   <= w_pre_nxt;
      r_value <= w_value_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  assign value = r_value;
  assign tc    = r_tc;

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
Parametrised up/down counter, generalising the team's fixed 8-bit free-running counter. Adds a power-of-two prescaler, a programmable wrap limit, runtime direction, synchronous load, an optional saturate mode and a terminal-count pulse. It drives display scan/refresh timing and general event timing. Single clock domain.

Parameters:
SIZE, 8, counter width in bits (1..32)
DIV, 0, prescaler width; the count steps once every 2^DIV enabled cycles (0 = every enabled cycle)
TOP, 0, wrap limit; 0 selects the natural limit 2^SIZE-1; must be < 2^SIZE
SATURATE, 0, 0 = wrap at the boundaries; 1 = hold at the boundaries

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
en  in  1  count enable; gates both the prescaler and the count
up  in  1  direction: 1 = increment, 0 = decrement; sampled on step cycles only
load  in  1  synchronous load strobe
load_value  in  SIZE  value written on load
value  out  SIZE  current count, registered
tc  out  1  terminal-count pulse, registered, one cycle wide

Behaviour:
- Reset, on rising clk with rst=1:
  - value=0, tc=0, prescaler=0.
  - rst asserted mid-prescale or mid-count aborts immediately; no tc is emitted.
- Priority, per edge: rst > load > step > hold.
- Limit L = TOP when TOP != 0, otherwise 2^SIZE-1.
- Prescaler:
  - DIV-bit register pre; when en=1, pre increments modulo 2^DIV.
  - step = en && (pre == 2^DIV-1). For DIV=0, step = en.
  - en=0 freezes pre and value.
- Load (load=1, rst=0):
  - value <= load_value, pre <= 0, tc <= 0.
  - en and up are ignored in that cycle.
  - load_value > L is accepted as-is.
- Step up:
  - value >= L: value <= 0 (SATURATE=0) or value <= L (SATURATE=1); tc <= 1.
  - Otherwise value <= value+1.
- Step down:
  - value == 0: value <= L (SATURATE=0) or value <= 0 (SATURATE=1); tc <= 1.
  - Otherwise value <= value-1. This includes values above L, which walk down normally.
- Saturate mode repeats tc on every step while held at a boundary. Software uses this to detect a parked counter.
- tc is 0 on every cycle not set above. A tc edge coincides with value showing the post-boundary count, so tc and the new value are visible together one cycle after the step edge.
- Latency: load and step take effect on the first rising edge. There is no combinational path from any input to any output.
- Arithmetic: modulo 2^SIZE internally. No carry out beyond tc.
- Direction change: up may toggle on any cycle. Only its value on a step cycle matters, and the prescaler is not disturbed.
- Simultaneous load and step: load wins, and the prescaler restarts from 0.

Test Plan:
1. SIZE=8, DIV=0, TOP=0: reset, en=1, up=1 for 260 cycles -> value 0,1,…,255,0,1,2,3; tc high only on the cycle value reads 0 after 255.
2. SIZE=4, TOP=9, DIV=2, en=1, up=1 -> value advances every 4 cycles 0..9,0; tc asserted once per 40 cycles; holding en=0 for 7 cycles mid-prescale delays the next step by exactly 7 cycles.
3. SIZE=4, TOP=9, up=0 from reset -> first step gives 9 with tc=1, then 8,7,…; load_value=12 then down steps -> 11,10,9,8 with no tc.
4. SATURATE=1, SIZE=4, TOP=0: load 14, up=1 -> 15 (tc=0), then 15 with tc=1 on every further step; up=0 -> 14, then continues down to 0 and holds with tc repeating.
5. DIV=3: assert load=1 with load_value=5 on a step cycle -> value=5, tc=0, next step exactly 8 enabled cycles later.
6. Assert rst for one cycle while value=7 and pre=mid-count -> next cycle value=0, tc=0, and the next step lands a full 2^DIV enabled cycles later.
